noc_local_rx: RTL and testbench



---
 rtl/noc_local_rx.sv | 205 ++++++++++++++++++++
 tb/tb_noc_local_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// noc_local_rx
//
// Terminating receiver at the local IP for one router output port. Flits come
// in under credit-based flow control and land in a small FIFO. A parser then
// walks the packets at the FIFO head: a header flit (destination in [7:0]), a
// size flit (payload count N), then N payload flits. Only the payload flits go
// to the IP, over a valid/ready stream with sop/eop markers. The destination and
// size of the current packet are held as sideband for the whole packet.
//
// Optional feature: define NOC_LOCAL_RX_STATS_EN to add saturating
// packet/flit counters (stat_pkts, stat_flits). When the macro is not defined,
// those ports and their logic do not exist.
//
// Ports:
//   clk          clock; all logic runs on posedge
//   rst          synchronous, active-low reset
//   tx           router presents a flit this cycle
//   data_in      flit from the router
//   credit       high when the receiver accepts a flit this cycle
//   out_valid    payload flit available to the IP
//   out_ready    IP accepts the payload flit
//   out_data     payload flit
//   out_sop      first payload flit of the packet
//   out_eop      last payload flit of the packet
//   out_dest     header[7:0] of the current packet
//   out_size     payload count N of the current packet
//   err_misroute one-cycle pulse: header destination != LOCAL_ADDR
//   err_zero_len one-cycle pulse: size flit == 0
//   stat_pkts    (stats build) packets delivered, saturating
//   stat_flits   (stats build) flits accepted into the FIFO, saturating
// -----------------------------------------------------------------------------
module noc_local_rx #(
    parameter int          FLIT_W     = 16,
    parameter int          DEPTH      = 4,
    parameter logic [7:0]  LOCAL_ADDR = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx,
    input  logic [FLIT_W-1:0] data_in,
    output logic              credit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [7:0]        out_dest,
    output logic [FLIT_W-1:0] out_size,
    output logic              err_misroute,
`ifdef NOC_LOCAL_RX_STATS_EN
    output logic [31:0]       stat_pkts,
    output logic [31:0]       stat_flits,
`endif
    output logic              err_zero_len
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_HDR,
        S_SIZE,
        S_PAYLOAD
    } state_t;

    // FIFO storage and bookkeeping
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [FLIT_W-1:0] head;
    logic              empty;
    logic              wr_en;
    logic              rd_en;

    // Parser state
    state_t            state;
    logic [FLIT_W-1:0] rem;
    logic              first;
    logic              rst_done;
    logic              xfer;

    assign empty  = (count == '0);
    assign head   = mem[rptr];

    // Credit comes only from registered state. This way the router never sees
    // a combinational path from its own tx back into credit.
    assign credit = rst_done && (count != CW'(DEPTH));
    assign wr_en  = tx && credit;

    // The output stream is presented straight from the FIFO head. out_valid
    // depends only on state and count, never on out_ready.
    assign out_valid = (state == S_PAYLOAD) && !empty;
    assign out_data  = head;
    assign out_sop   = (state == S_PAYLOAD) && first;
    assign out_eop   = (state == S_PAYLOAD) && (rem == FLIT_W'(1));
    assign xfer      = out_valid && out_ready;

    // Header and size flits are consumed internally as soon as they reach the
    // head. A payload flit leaves only on an accepted transfer.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        rd_en = 1'b0;
        case (state)
            S_HDR,
            S_SIZE:    rd_en = !empty;
            S_PAYLOAD: rd_en = xfer;
            default:   rd_en = 1'b0;
        endcase
    end

    // rst_done holds credit low for the first cycle after reset is released.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its inputs as they were before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) rst_done <= 1'b0;
        else      rst_done <= 1'b1;
    end

    // NOTE: the storage array is not reset. Clearing the pointers and count
    // discards its contents, and a reset term would block a RAM mapping.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= data_in;
    end

    // Pointers wrap naturally because DEPTH is a power of two. A write and a
    // pop in the same cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (rd_en) rptr <= rptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Packet parser
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_HDR;
            rem          <= '0;
            first        <= 1'b0;
            out_dest     <= '0;
            out_size     <= '0;
            err_misroute <= 1'b0;
            err_zero_len <= 1'b0;
        end else begin
            err_misroute <= 1'b0;
            err_zero_len <= 1'b0;
            case (state)
                S_HDR: begin
                    if (!empty) begin
                        out_dest <= head[7:0];
                        // A misrouted packet is still delivered; it is only flagged.
                        err_misroute <= (head[7:0] != LOCAL_ADDR);
                        state <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    if (!empty) begin
                        out_size <= head;
                        rem      <= head;
                        if (head == '0) begin
                            err_zero_len <= 1'b1;
                            state        <= S_HDR;
                        end else begin
                            first <= 1'b1;
                            state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (xfer) begin
                        rem   <= rem - FLIT_W'(1);
                        first <= 1'b0;
                        if (rem == FLIT_W'(1)) state <= S_HDR;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

`ifdef NOC_LOCAL_RX_STATS_EN
    // Saturating counters: each one stops at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_pkts  <= '0;
            stat_flits <= '0;
        end else begin
            if (xfer && out_eop && (stat_pkts != 32'hFFFF_FFFF))
                stat_pkts <= stat_pkts + 32'd1;
            if (wr_en && (stat_flits != 32'hFFFF_FFFF))
                stat_flits <= stat_flits + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_local_rx.sv
`timescale 1ns/1ps
// Directed testbench for noc_local_rx (FLIT_W=16, DEPTH=4, LOCAL_ADDR=0).
module tb_noc_local_rx;

    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tx = 1'b0;
    logic [FW-1:0] data_in = '0;
    logic          out_ready = 1'b0;
    logic          credit;
    logic          out_valid;
    logic [FW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [7:0]    out_dest;
    logic [FW-1:0] out_size;
    logic          err_misroute;
    logic          err_zero_len;
`ifdef NOC_LOCAL_RX_STATS_EN
    logic [31:0]   stat_pkts;
    logic [31:0]   stat_flits;
`endif

    noc_local_rx #(.FLIT_W(FW), .DEPTH(4), .LOCAL_ADDR(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx           (tx),
        .data_in      (data_in),
        .credit       (credit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_dest     (out_dest),
        .out_size     (out_size),
        .err_misroute (err_misroute),
`ifdef NOC_LOCAL_RX_STATS_EN
        .stat_pkts    (stat_pkts),
        .stat_flits   (stat_flits),
`endif
        .err_zero_len (err_zero_len)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: records every accepted payload transfer and counts error pulses.
    logic [FW-1:0] rx_data [64];
    logic          rx_sop  [64];
    logic          rx_eop  [64];
    logic [7:0]    rx_dest [64];
    int            rx_n    = 0;
    int            mis_cnt = 0;
    int            zl_cnt  = 0;

    always @(negedge clk) begin
        if (out_valid && out_ready && rx_n < 64) begin
            rx_data[rx_n] <= out_data;
            rx_sop[rx_n]  <= out_sop;
            rx_eop[rx_n]  <= out_eop;
            rx_dest[rx_n] <= out_dest;
            rx_n          <= rx_n + 1;
        end
        if (err_misroute) mis_cnt <= mis_cnt + 1;
        if (err_zero_len) zl_cnt  <= zl_cnt + 1;
    end

    // Presents one flit and holds it until it is accepted. Must be called at
    // posedge+1 and returns at posedge+1.
    task automatic send(input logic [FW-1:0] f);
        int n;
        n = 0;
        tx = 1'b1;
        data_in = f;
        @(negedge clk);
        while (!credit && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!credit) check("send_credit_timeout", {31'd0, credit}, 32'd1);
        @(posedge clk);
        #1;
        tx = 1'b0;
    endtask

    // Waits for the total delivered count to reach target, then lets the
    // design idle to expose extra or duplicate deliveries. Returns at posedge+1.
    task automatic wait_rx(input int target);
        int n;
        n = 0;
        while (rx_n < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("rx_count", rx_n, target);
        @(posedge clk);
        #1;
    endtask

    task automatic check_item(input string tag, input int idx, input logic [FW-1:0] d,
                              input logic s, input logic e, input logic [7:0] dst);
        check({tag, "_data"}, {16'd0, rx_data[idx]}, {16'd0, d});
        check({tag, "_sop"},  {31'd0, rx_sop[idx]},  {31'd0, s});
        check({tag, "_eop"},  {31'd0, rx_eop[idx]},  {31'd0, e});
        check({tag, "_dest"}, {24'd0, rx_dest[idx]}, {24'd0, dst});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int m0;
        int z0;

        // ---------------- Reset and release ----------------
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_credit",    {31'd0, credit},       32'd0);
        check("rst_valid",     {31'd0, out_valid},    32'd0);
        check("rst_sop",       {31'd0, out_sop},      32'd0);
        check("rst_eop",       {31'd0, out_eop},      32'd0);
        check("rst_dest",      {24'd0, out_dest},     32'd0);
        check("rst_size",      {16'd0, out_size},     32'd0);
        check("rst_misroute",  {31'd0, err_misroute}, 32'd0);
        check("rst_zero_len",  {31'd0, err_zero_len}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("release_credit_first_cycle", {31'd0, credit}, 32'd0);
        @(posedge clk);
        #1;
        check("release_credit_next_cycle", {31'd0, credit}, 32'd1);
        check("release_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- Basic 3-flit packet ----------------
        out_ready = 1'b1;
        base = rx_n; m0 = mis_cnt; z0 = zl_cnt;
        send(16'h0000); send(16'h0003);
        send(16'h00A1); send(16'h00A2); send(16'h00A3);
        wait_rx(base + 3);
        check_item("basic0", base,     16'h00A1, 1'b1, 1'b0, 8'h00);
        check_item("basic1", base + 1, 16'h00A2, 1'b0, 1'b0, 8'h00);
        check_item("basic2", base + 2, 16'h00A3, 1'b0, 1'b1, 8'h00);
        check("basic_size", {16'd0, out_size}, 32'd3);
        check("basic_misroute_pulses", mis_cnt - m0, 0);
        check("basic_zero_len_pulses", zl_cnt - z0, 0);

        // ---------------- Backpressure and full FIFO ----------------
        out_ready = 1'b0;
        base = rx_n; m0 = mis_cnt;
        send(16'h0000); send(16'h0004);
        send(16'h00C1); send(16'h00C2); send(16'h00C3); send(16'h00C4);
        // Four payloads are now buffered; extra flits offered must be dropped.
        tx = 1'b1;
        data_in = 16'hDEAD;
        repeat (3) begin
            @(negedge clk);
            check("full_credit_low", {31'd0, credit}, 32'd0);
        end
        check("full_valid_held", {31'd0, out_valid}, 32'd1);
        check("full_data_held", {16'd0, out_data}, 32'h00C1);
        @(posedge clk);
        #1;
        tx = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("full_pop_same_cycle_credit", {31'd0, credit}, 32'd0);
        @(negedge clk);
        check("credit_returns", {31'd0, credit}, 32'd1);
        wait_rx(base + 4);
        check_item("bp0", base,     16'h00C1, 1'b1, 1'b0, 8'h00);
        check_item("bp1", base + 1, 16'h00C2, 1'b0, 1'b0, 8'h00);
        check_item("bp2", base + 2, 16'h00C3, 1'b0, 1'b0, 8'h00);
        check_item("bp3", base + 3, 16'h00C4, 1'b0, 1'b1, 8'h00);
        // A wrongly accepted 0xDEAD would be parsed as a header and misrouted.
        check("bp_no_extra_header", mis_cnt - m0, 0);

        // ---------------- Misrouted packet ----------------
        base = rx_n; m0 = mis_cnt;
        send(16'h0012); send(16'h0001); send(16'hBEEF);
        wait_rx(base + 1);
        check_item("misroute", base, 16'hBEEF, 1'b1, 1'b1, 8'h12);
        check("misroute_pulses", mis_cnt - m0, 1);
        check("misroute_dest", {24'd0, out_dest}, 32'h12);

        // ---------------- Zero-length then 1-flit packet ----------------
        base = rx_n; z0 = zl_cnt; m0 = mis_cnt;
        send(16'h0000); send(16'h0000);
        send(16'h0000); send(16'h0001); send(16'h0055);
        wait_rx(base + 1);
        check_item("after_zero", base, 16'h0055, 1'b1, 1'b1, 8'h00);
        check("zero_len_pulses", zl_cnt - z0, 1);
        check("zero_len_no_misroute", mis_cnt - m0, 0);

        // ---------------- Reset mid-packet ----------------
        base = rx_n;
        send(16'h0000); send(16'h0005);
        send(16'h00D1); send(16'h00D2);
        wait_rx(base + 2);
        check_item("pre_rst0", base,     16'h00D1, 1'b1, 1'b0, 8'h00);
        check_item("pre_rst1", base + 1, 16'h00D2, 1'b0, 1'b0, 8'h00);
        out_ready = 1'b0;
        send(16'h00D3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_credit", {31'd0, credit},    32'd0);
        check("midrst_valid",  {31'd0, out_valid}, 32'd0);
        check("midrst_sop",    {31'd0, out_sop},   32'd0);
        check("midrst_eop",    {31'd0, out_eop},   32'd0);
        check("midrst_dest",   {24'd0, out_dest},  32'd0);
        check("midrst_size",   {16'd0, out_size},  32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_credit_back", {31'd0, credit}, 32'd1);
        check("midrst_fifo_flushed", {31'd0, out_valid}, 32'd0);
`ifdef NOC_LOCAL_RX_STATS_EN
        check("stat_pkts_cleared",  stat_pkts,  32'd0);
        check("stat_flits_cleared", stat_flits, 32'd0);
`endif
        out_ready = 1'b1;
        base = rx_n;
        send(16'h0000); send(16'h0001); send(16'h0077);
        wait_rx(base + 1);
        check_item("post_rst", base, 16'h0077, 1'b1, 1'b1, 8'h00);
`ifdef NOC_LOCAL_RX_STATS_EN
        check("stat_pkts_after",  stat_pkts,  32'd1);
        check("stat_flits_after", stat_flits, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
